// File: rtl/sram_ctrl.sv
// Asynchronous-SRAM controller: turns a single CPU load/store request into a timed SRAM strobe sequence.
// Latency: read stalls WAIT_CYCLES+1 cycles (data valid in DONE), write stalls WAIT_CYCLES+2 cycles.
// Backpressure: stall_o holds the requester from the request cycle until the access leaves WREC/READ.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_ce_n_i,
    input  logic        cpu_we_n_i,
    input  logic        cpu_oe_n_i,
    input  logic [3:0]  cpu_be_n_i,
    output logic [31:0] cpu_data_o,
    output logic        stall_o,
    output logic [19:0] sram_addr_o,
    input  logic [31:0] sram_dq_i,
    output logic [31:0] sram_dq_o,
    output logic        sram_dq_oe_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        WREC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Strobe phases count down from WAIT_CYCLES-1 to 0, so the phase lasts WAIT_CYCLES cycles.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [19:0] addr_q;
    logic [31:0] data_q;
    logic        req;

    // Only word-address bits 21:2 reach the SRAM; the rest of the byte address is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr_i[31:22], cpu_addr_i[1:0]};

    // A request needs the select plus at least one strobe; select alone is a no-op.
    assign req = ~cpu_ce_n_i & (~cpu_we_n_i | ~cpu_oe_n_i);

    // Captured address and data feed the SRAM directly so they stay stable through WREC hold time.
    assign sram_addr_o = addr_q;
    assign sram_dq_o   = data_q;

    // Hold the pipeline from the request cycle until the SRAM access (and write recovery) is over.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:              stall_o = req;
            READ, WRITE, WREC: stall_o = 1'b1;
            default:           stall_o = 1'b0;
        endcase
    end

    // Access sequencer; every SRAM-facing output is a flop updated on the state transition into its phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr_q       <= 20'd0;
            data_q       <= 32'd0;
            cpu_data_o   <= 32'd0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            sram_be_n_o  <= 4'b1111;
            sram_dq_oe_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q      <= cpu_addr_i[21:2];
                        data_q      <= cpu_data_i;
                        sram_be_n_o <= cpu_be_n_i;
                        cnt         <= CNT_LOAD;
                        sram_ce_n_o <= 1'b0;
                        // Write has priority when both strobes are low.
                        if (!cpu_we_n_i) begin
                            state        <= WRITE;
                            sram_we_n_o  <= 1'b0;
                            sram_dq_oe_o <= 1'b1;
                        end else begin
                            state       <= READ;
                            sram_oe_n_o <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (cnt == 4'd0) begin
                        cpu_data_o  <= sram_dq_i;
                        state       <= DONE;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_be_n_o <= 4'b1111;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WRITE: begin
                    if (cnt == 4'd0) begin
                        // Release WE first; CE, data and bus drive stay one more cycle for hold time.
                        state       <= WREC;
                        sram_we_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WREC: begin
                    state        <= DONE;
                    sram_ce_n_o  <= 1'b1;
                    sram_dq_oe_o <= 1'b0;
                    sram_be_n_o  <= 4'b1111;
                end
                DONE: begin
                    // The requester advances on this edge; its inputs are not looked at here.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed accesses on a WAIT_CYCLES=2 instance checked every cycle
// against a transaction-schedule model, plus literal checks and stall-length checks on WAIT_CYCLES=1 and 15
// instances that share the same stimulus bus but have their own select.
module tb_sram_ctrl;

    localparam int MW = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] cpu_addr, cpu_data_in, sram_dq_i;
    logic        ce_n, ce_n1, ce_n15, we_n, oe_n;
    logic [3:0]  be_n;

    logic [31:0] data_o, dq_o;
    logic [19:0] addr_o;
    logic        stall, dq_oe, s_ce_n, s_oe_n, s_we_n;
    logic [3:0]  s_be_n;

    logic [31:0] data_o1, dq_o1, data_o15, dq_o15;
    logic [19:0] addr_o1, addr_o15;
    logic        stall1, dq_oe1, ce_o1, oe_o1, we_o1;
    logic        stall15, dq_oe15, ce_o15, oe_o15, we_o15;
    logic [3:0]  be_o1, be_o15;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sram_ctrl #(.WAIT_CYCLES(MW)) dut (
        .clk(clk), .rst(rst), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data_in),
        .cpu_ce_n_i(ce_n), .cpu_we_n_i(we_n), .cpu_oe_n_i(oe_n), .cpu_be_n_i(be_n),
        .cpu_data_o(data_o), .stall_o(stall), .sram_addr_o(addr_o), .sram_dq_i(sram_dq_i),
        .sram_dq_o(dq_o), .sram_dq_oe_o(dq_oe), .sram_ce_n_o(s_ce_n), .sram_oe_n_o(s_oe_n),
        .sram_we_n_o(s_we_n), .sram_be_n_o(s_be_n)
    );

    sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data_in),
        .cpu_ce_n_i(ce_n1), .cpu_we_n_i(we_n), .cpu_oe_n_i(oe_n), .cpu_be_n_i(be_n),
        .cpu_data_o(data_o1), .stall_o(stall1), .sram_addr_o(addr_o1), .sram_dq_i(sram_dq_i),
        .sram_dq_o(dq_o1), .sram_dq_oe_o(dq_oe1), .sram_ce_n_o(ce_o1), .sram_oe_n_o(oe_o1),
        .sram_we_n_o(we_o1), .sram_be_n_o(be_o1)
    );

    sram_ctrl #(.WAIT_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data_in),
        .cpu_ce_n_i(ce_n15), .cpu_we_n_i(we_n), .cpu_oe_n_i(oe_n), .cpu_be_n_i(be_n),
        .cpu_data_o(data_o15), .stall_o(stall15), .sram_addr_o(addr_o15), .sram_dq_i(sram_dq_i),
        .sram_dq_o(dq_o15), .sram_dq_oe_o(dq_oe15), .sram_ce_n_o(ce_o15), .sram_oe_n_o(oe_o15),
        .sram_we_n_o(we_o15), .sram_be_n_o(be_o15)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // ---------------- behavioural model: per-cycle expectation schedule ----------------
    typedef struct {
        logic        ce_n, oe_n, we_n, dq_oe, stall;
        logic        chk_be, chk_addr, chk_dq, latch;
        logic [3:0]  be_n;
        logic [19:0] addr;
        logic [31:0] dq;
    } exp_t;

    exp_t        sched[$];
    logic [31:0] exp_data;

    function automatic exp_t mk(input logic ce, input logic oe, input logic we, input logic doe,
                                input logic st, input logic cb, input logic [3:0] b,
                                input logic ca, input logic [19:0] a, input logic cd,
                                input logic [31:0] d, input logic lt);
        exp_t e;
        e.ce_n = ce; e.oe_n = oe; e.we_n = we; e.dq_oe = doe; e.stall = st;
        e.chk_be = cb; e.be_n = b; e.chk_addr = ca; e.addr = a;
        e.chk_dq = cd; e.dq = d; e.latch = lt;
        return e;
    endfunction

    // An accepted request expands into: MW strobe cycles, (write only) one recovery cycle, one DONE cycle.
    task automatic plan(input logic wr, input logic [19:0] a, input logic [31:0] d, input logic [3:0] b);
        for (int i = 0; i < MW; i++) begin
            if (wr) sched.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, b, 1'b1, a, 1'b1, d, 1'b0));
            else    sched.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, b, 1'b1, a, 1'b0, d, i == MW - 1));
        end
        if (wr) sched.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, b, 1'b1, a, 1'b1, d, 1'b0));
        sched.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, a, 1'b0, d, 1'b0));
    endtask

    always @(negedge clk or posedge rst) begin : model_cmp
        exp_t e;
        logic rq;
        if (rst) begin
            sched.delete();
            exp_data = 32'd0;
        end else begin
            rq = !ce_n && (!we_n || !oe_n);
            if (sched.size() > 0) begin
                e = sched.pop_front();
            end else begin
                e = mk(1'b1, 1'b1, 1'b1, 1'b0, rq, 1'b1, 4'hF, 1'b0, 20'd0, 1'b0, 32'd0, 1'b0);
                if (rq) plan(!we_n, cpu_addr[21:2], cpu_data_in, be_n);
            end
            check("m_sram_ce_n", {31'd0, s_ce_n}, {31'd0, e.ce_n});
            check("m_sram_oe_n", {31'd0, s_oe_n}, {31'd0, e.oe_n});
            check("m_sram_we_n", {31'd0, s_we_n}, {31'd0, e.we_n});
            check("m_sram_dq_oe", {31'd0, dq_oe}, {31'd0, e.dq_oe});
            check("m_stall", {31'd0, stall}, {31'd0, e.stall});
            if (e.chk_be)   check("m_sram_be_n", {28'd0, s_be_n}, {28'd0, e.be_n});
            if (e.chk_addr) check("m_sram_addr", {12'd0, addr_o}, {12'd0, e.addr});
            if (e.chk_dq)   check("m_sram_dq_o", dq_o, e.dq);
            check("m_cpu_data", data_o, exp_data);
            if (e.latch) exp_data = sram_dq_i;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        @(posedge clk); #1;
        ce_n = 1'b1; ce_n1 = 1'b1; ce_n15 = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    endtask

    // which: 0 = main instance, 1 = WAIT_CYCLES=1, 2 = WAIT_CYCLES=15. Returns at the DONE cycle.
    task automatic access(input int which, input logic w_n, input logic o_n, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b, output int nstall, output int nwe,
                          output int nrec, output logic [3:0] be_seen, output logic [31:0] dq_seen,
                          output int first_c, output int done_c);
        logic s;
        @(posedge clk); #1;
        cpu_addr = a; cpu_data_in = d; be_n = b; we_n = w_n; oe_n = o_n;
        ce_n   = (which == 0) ? 1'b0 : 1'b1;
        ce_n1  = (which == 1) ? 1'b0 : 1'b1;
        ce_n15 = (which == 2) ? 1'b0 : 1'b1;
        nstall = 0; nwe = 0; nrec = 0; be_seen = 4'hF; dq_seen = 32'd0; first_c = -1; done_c = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            s = (which == 0) ? stall : (which == 1) ? stall1 : stall15;
            if (s) begin
                nstall++;
                if (first_c < 0) first_c = cyc;
            end
            if (which == 0 && !s_we_n) begin
                nwe++;
                be_seen = s_be_n;
                dq_seen = dq_o;
            end
            if (which == 0 && !s_ce_n && s_we_n && dq_oe) nrec++;
            if (!s && nstall > 0) begin
                done_c = cyc;
                break;
            end
        end
        check("access_completes", {31'd0, done_c >= 0}, 32'd1);
    endtask

    int          ns, nw, nr, fc, dc, fc2, dc2;
    logic [3:0]  bs;
    logic [31:0] ds;

    initial begin
        rst = 1'b0; ce_n = 1'b1; ce_n1 = 1'b1; ce_n15 = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        be_n = 4'hF; cpu_addr = 32'd0; cpu_data_in = 32'd0; sram_dq_i = 32'd0;
        #1 rst = 1'b1;
        #1;
        check("rst_cpu_data", data_o, 32'd0);
        check("rst_ce_n", {31'd0, s_ce_n}, 32'd1);
        check("rst_oe_n", {31'd0, s_oe_n}, 32'd1);
        check("rst_we_n", {31'd0, s_we_n}, 32'd1);
        check("rst_be_n", {28'd0, s_be_n}, 32'hF);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_addr", {12'd0, addr_o}, 32'd0);
        check("rst_dq_o", dq_o, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Read at 0x10 -> word 4, three stall cycles, data valid in DONE.
        sram_dq_i = 32'hDEADBEEF;
        access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, ns, nw, nr, bs, ds, fc, dc);
        check("rd_stall_len", ns, 32'd3);
        check("rd_data", data_o, 32'hDEADBEEF);
        check("rd_addr", {12'd0, addr_o}, 32'h4);
        idle();

        // Byte write, lanes 3 only enabled (be_n=0111), bus data must not disturb cpu_data_o.
        sram_dq_i = 32'h1234_5678;
        access(0, 1'b0, 1'b1, 32'h0000_0007, 32'h5A5A5A5A, 4'b0111, ns, nw, nr, bs, ds, fc, dc);
        check("wr_stall_len", ns, 32'd4);
        check("wr_we_low_cycles", nw, 32'd2);
        check("wr_recovery_cycles", nr, 32'd1);
        check("wr_be_n", {28'd0, bs}, 32'h7);
        check("wr_dq_o", ds, 32'h5A5A5A5A);
        check("wr_addr", {12'd0, addr_o}, 32'h1);
        check("wr_keeps_cpu_data", data_o, 32'hDEADBEEF);
        idle();

        // Both strobes low -> write wins.
        sram_dq_i = 32'h0BADF00D;
        access(0, 1'b0, 1'b0, 32'h0000_0008, 32'h77777777, 4'b0000, ns, nw, nr, bs, ds, fc, dc);
        check("both_we_low_cycles", nw, 32'd2);
        check("both_stall_len", ns, 32'd4);
        check("both_cpu_data_kept", data_o, 32'hDEADBEEF);
        idle();

        // Select with no strobe: no stall, no SRAM activity.
        @(posedge clk); #1;
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noop_stall", {31'd0, stall}, 32'd0);
            check("noop_ce_n", {31'd0, s_ce_n}, 32'd1);
        end
        idle();

        // Back-to-back read then write: exactly one DONE cycle between them.
        sram_dq_i = 32'h13579BDF;
        access(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000, ns, nw, nr, bs, ds, fc, dc);
        check("b2b_rd_stall_len", ns, 32'd3);
        check("b2b_rd_data", data_o, 32'h13579BDF);
        access(0, 1'b0, 1'b1, 32'h0000_0044, 32'h24682468, 4'b0000, ns, nw, nr, bs, ds, fc2, dc2);
        check("b2b_gap_cycles", fc2 - dc, 32'd1);
        check("b2b_wr_stall_len", ns, 32'd4);
        check("b2b_wr_we_low", nw, 32'd2);
        idle();

        // Reset in the second WRITE cycle aborts the access without a clock edge.
        @(posedge clk); #1;
        cpu_addr = 32'h20; cpu_data_in = 32'h11223344; be_n = 4'b0000; we_n = 1'b0; oe_n = 1'b1; ce_n = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_we_n", {31'd0, s_we_n}, 32'd0);
        #1;
        ce_n = 1'b1; we_n = 1'b1;
        rst = 1'b1;
        #1;
        check("abort_ce_n", {31'd0, s_ce_n}, 32'd1);
        check("abort_we_n", {31'd0, s_we_n}, 32'd1);
        check("abort_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("abort_be_n", {28'd0, s_be_n}, 32'hF);
        check("abort_addr", {12'd0, addr_o}, 32'd0);
        check("abort_dq_o", dq_o, 32'd0);
        check("abort_cpu_data", data_o, 32'd0);
        check("abort_stall", {31'd0, stall}, 32'd0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        sram_dq_i = 32'hCAFEF00D;
        access(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b0000, ns, nw, nr, bs, ds, fc, dc);
        check("post_rst_stall_len", ns, 32'd3);
        check("post_rst_data", data_o, 32'hCAFEF00D);
        check("post_rst_addr", {12'd0, addr_o}, 32'h40);
        idle();

        // WAIT_CYCLES extremes.
        sram_dq_i = 32'hA5A5_0001;
        access(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, ns, nw, nr, bs, ds, fc, dc);
        check("w1_stall_len", ns, 32'd2);
        check("w1_data", data_o1, 32'hA5A5_0001);
        idle();
        sram_dq_i = 32'h5A5A_000F;
        access(2, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, ns, nw, nr, bs, ds, fc, dc);
        check("w15_stall_len", ns, 32'd16);
        check("w15_data", data_o15, 32'h5A5A_000F);
        idle();
        access(2, 1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'b0000, ns, nw, nr, bs, ds, fc, dc);
        check("w15_again_stall_len", ns, 32'd16);
        idle();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
